// File: rtl/obi_rr_multi_arbiter.sv
// obi_rr_multi_arbiter
// Shares one OBI-style data port (typically a data cache core_if) among
// NR_MASTER_PORTS requesters. Arbitration is round-robin, and a request that is
// not yet granted stays locked in. Up to MAX_OUTSTANDING granted transactions
// may be in flight. An in-order ID FIFO routes each response back to the master
// that issued the request.
//
// Optional feature: define OBI_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (the lowest index wins). Lock-in still applies in that mode.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m_req_i / m_gnt_o        per-master request / zero-cycle grant
//   m_we_i, m_be_i,          per-master request fields (packed, master 0 in
//   m_addr_i, m_wdata_i      the LSBs)
//   m_rvalid_o               per-master response valid
//   m_rdata_o, m_err_o       response data / error, broadcast to all masters
//   s_req_o / s_gnt_i        shared-port request / grant
//   s_we_o, s_be_o,          request fields of the selected master
//   s_addr_o, s_wdata_o
//   s_rvalid_i, s_rdata_i,   shared-port response
//   s_err_i
//   resp_orphan_o            sticky: a response arrived with nothing in flight
//   outstanding_o            number of transactions in flight
module obi_rr_multi_arbiter #(
  parameter int unsigned NR_MASTER_PORTS = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NR_MASTER_PORTS-1:0]               m_req_i,
  output logic [NR_MASTER_PORTS-1:0]               m_gnt_o,
  input  logic [NR_MASTER_PORTS-1:0]               m_we_i,
  input  logic [NR_MASTER_PORTS*(DATA_WIDTH/8)-1:0] m_be_i,
  input  logic [NR_MASTER_PORTS*ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NR_MASTER_PORTS*DATA_WIDTH-1:0]    m_wdata_i,
  output logic [NR_MASTER_PORTS-1:0]               m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    m_rdata_o,
  output logic                                     m_err_o,
  output logic                                     s_req_o,
  input  logic                                     s_gnt_i,
  output logic                                     s_we_o,
  output logic [DATA_WIDTH/8-1:0]                  s_be_o,
  output logic [ADDR_WIDTH-1:0]                    s_addr_o,
  output logic [DATA_WIDTH-1:0]                    s_wdata_o,
  input  logic                                     s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
  input  logic                                     s_err_i,
  output logic                                     resp_orphan_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

  localparam int unsigned N     = NR_MASTER_PORTS;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_e;

  // Unpacked views of the packed per-master request fields
  logic [ADDR_WIDTH-1:0] addr_arr  [N];
  logic [DATA_WIDTH-1:0] wdata_arr [N];
  logic [BE_W-1:0]       be_arr    [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = m_be_i[g*BE_W +: BE_W];
  end

  lock_state_e lock_state_q, lock_state_d;
  idx_t        lock_idx_q, lock_idx_d;
  idx_t        arb_idx;
  idx_t        sel;
  logic        lock_valid;
  logic        full;
  logic        hs;

  idx_t        fifo_q [MAX_OUTSTANDING];
  ptr_t        wr_ptr_q, rd_ptr_q;
  cnt_t        count_q;
  logic        orphan_q;
  logic        push, pop;
  idx_t        head;

`ifdef OBI_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index requester wins
  always_comb begin : arb_search
    logic found;
    found   = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && m_req_i[idx_t'(i)]) begin
        found   = 1'b1;
        arb_idx = idx_t'(i);
      end
    end
  end
`else
  idx_t rr_ptr_q;

  // Round-robin: the first requester at or after rr_ptr_q, wrapping from N-1 to 0
  always_comb begin : arb_search
    logic             found;
    logic [IDX_W:0]   cand;
    found   = 1'b0;
    cand    = '0;
    arb_idx = rr_ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && m_req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        arb_idx = cand[IDX_W-1:0];
      end
    end
  end

  // The pointer moves just past the master that was granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (sel == idx_t'(N - 1)) ? '0 : sel + idx_t'(1);
    end
  end
`endif

  // A lock only steers selection while its master keeps requesting. If the
  // master drops its request, arbitration proceeds normally and the lock
  // clears on the next edge.
  assign lock_valid = (lock_state_q == LOCK_HELD) && m_req_i[lock_idx_q];
  assign sel        = lock_valid ? lock_idx_q : arb_idx;

  assign full    = (count_q == cnt_t'(MAX_OUTSTANDING));
  assign s_req_o = (|m_req_i) & ~full & ~rst;
  assign hs      = s_req_o & s_gnt_i;

  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = be_arr[sel];
  assign s_addr_o  = addr_arr[sel];
  assign s_wdata_o = wdata_arr[sel];

  // Zero-cycle grant back to the selected master
  always_comb begin
    m_gnt_o = '0;
    if (hs) m_gnt_o[sel] = 1'b1;
  end

  // Lock state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state_q <= LOCK_IDLE;
      lock_idx_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

  // Lock next state: hold an ungranted request until its handshake completes
  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    if (hs) begin
      lock_state_d = LOCK_IDLE;
    end else if (lock_valid) begin
      lock_state_d = LOCK_HELD;
    end else if (s_req_o) begin
      lock_state_d = LOCK_HELD;
      lock_idx_d   = sel;
    end else begin
      lock_state_d = LOCK_IDLE;
    end
  end

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // full blocks s_req_o, so a push never hits a full FIFO
  assign push = hs;
  assign pop  = s_rvalid_i & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  // In-order ID FIFO of granted master indices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + cnt_t'(1);
      else if (pop && !push) count_q <= count_q - cnt_t'(1);
      if (s_rvalid_i && (count_q == '0)) orphan_q <= 1'b1;
    end
  end

  // Response routing to the oldest in-flight master
  always_comb begin
    m_rvalid_o = '0;
    if (pop) m_rvalid_o[head] = 1'b1;
  end

  assign m_rdata_o     = s_rdata_i;
  assign m_err_o       = s_err_i;
  assign resp_orphan_o = orphan_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_obi_rr_multi_arbiter.sv
// Directed bench for obi_rr_multi_arbiter with the default parameters
// (4 masters, 2 outstanding). Inputs change 1 time unit after the rising edge,
// and outputs are checked 2 time units later.
module tb_obi_rr_multi_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_gnt, m_we, m_rvalid;
  logic [N*BW-1:0] m_be;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic            s_req, s_gnt, s_we;
  logic [BW-1:0]   s_be;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            s_err;
  logic            orphan;
  logic [1:0]      outstanding;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obi_rr_multi_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .m_req_i       (m_req),
    .m_gnt_o       (m_gnt),
    .m_we_i        (m_we),
    .m_be_i        (m_be),
    .m_addr_i      (m_addr),
    .m_wdata_i     (m_wdata),
    .m_rvalid_o    (m_rvalid),
    .m_rdata_o     (m_rdata),
    .m_err_o       (m_err),
    .s_req_o       (s_req),
    .s_gnt_i       (s_gnt),
    .s_we_o        (s_we),
    .s_be_o        (s_be),
    .s_addr_o      (s_addr),
    .s_wdata_o     (s_wdata),
    .s_rvalid_i    (s_rvalid),
    .s_rdata_i     (s_rdata),
    .s_err_i       (s_err),
    .resp_orphan_o (orphan),
    .outstanding_o (outstanding)
  );

  function automatic logic [AW-1:0] addr_of(input int unsigned i);
    return 32'h1000_0000 + 32'(i * 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv);
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    #2;
  endtask

  initial begin
    rst      = 1'b1;
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = 32'hCAFE_0001;
    s_err    = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = addr_of(i);
      m_wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      m_be[i*BW +: BW]    = 4'(i + 1);
      m_we[i]             = (i % 2) == 1;
    end

    // Reset state
    #3;
    chk("rst_gnt", 32'(m_gnt), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid), 32'h0);
    chk("rst_sreq", 32'(s_req), 32'h0);
    chk("rst_orphan", 32'(orphan), 32'h0);
    chk("rst_outst", 32'(outstanding), 32'h0);
    chk("rst_addr", s_addr, addr_of(0));
    chk("rst_rdata", m_rdata, 32'hCAFE_0001);
    chk("rst_err", 32'(m_err), 32'h1);
    tick();
    rst = 1'b0;

`ifndef OBI_ARB_FIXED_PRIO_EN
    // Round-robin with all masters requesting and a response one cycle after each grant
    for (int k = 0; k < 4; k++) begin
      drive(4'hF, 1'b1, k != 0);
      chk($sformatf("rr_gnt%0d", k), 32'(m_gnt), 32'(1 << k));
      chk($sformatf("rr_rv%0d", k), 32'(m_rvalid), (k == 0) ? 32'h0 : 32'(1 << (k - 1)));
      chk($sformatf("rr_outst%0d", k), 32'(outstanding), (k == 0) ? 32'h0 : 32'h1);
      tick();
    end
    drive(4'h0, 1'b0, 1'b1);
    chk("rr_drain_rv", 32'(m_rvalid), 32'h8);
    tick();
`endif

    // Lock: master 2 is held while the grant is low, even once master 0 requests
    drive(4'b0100, 1'b0, 1'b0);
    chk("lk_sreq", 32'(s_req), 32'h1);
    chk("lk_gnt0", 32'(m_gnt), 32'h0);
    chk("lk_addr0", s_addr, addr_of(2));
    tick();
    drive(4'b0100, 1'b0, 1'b0);
    chk("lk_addr1", s_addr, addr_of(2));
    tick();
    drive(4'b0101, 1'b0, 1'b0);
    chk("lk_addr2", s_addr, addr_of(2));
    chk("lk_wdata2", s_wdata, 32'hD000_0002);
    chk("lk_be2", 32'(s_be), 32'h3);
    chk("lk_we2", 32'(s_we), 32'h0);
    tick();
    drive(4'b0101, 1'b1, 1'b0);
    chk("lk_gnt_m2", 32'(m_gnt), 32'h4);
    tick();
    drive(4'b0001, 1'b1, 1'b0);
    chk("lk_gnt_m0", 32'(m_gnt), 32'h1);
    chk("lk_outst", 32'(outstanding), 32'h1);
    tick();

    // Full: two transactions in flight block new grants until the cycle after a pop
    drive(4'b0010, 1'b1, 1'b0);
    chk("full_sreq", 32'(s_req), 32'h0);
    chk("full_gnt", 32'(m_gnt), 32'h0);
    chk("full_outst", 32'(outstanding), 32'h2);
    tick();
    drive(4'b0010, 1'b1, 1'b1);
    chk("full_pop_rv", 32'(m_rvalid), 32'h4);
    chk("full_pop_gnt", 32'(m_gnt), 32'h0);
    tick();
    drive(4'b0010, 1'b1, 1'b0);
    chk("full_resume_gnt", 32'(m_gnt), 32'h2);
    chk("full_resume_outst", 32'(outstanding), 32'h1);
    chk("full_resume_we", 32'(s_we), 32'h1);
    tick();

    // Drain entries 0 then 1
    drive(4'b0000, 1'b0, 1'b1);
    chk("drain_rv0", 32'(m_rvalid), 32'h1);
    tick();
    drive(4'b0000, 1'b0, 1'b1);
    chk("drain_rv1", 32'(m_rvalid), 32'h2);
    tick();

    // Push (master 1) and pop (master 3) in the same cycle
    drive(4'b1000, 1'b1, 1'b0);
    chk("pp_gnt3", 32'(m_gnt), 32'h8);
    tick();
    drive(4'b0010, 1'b1, 1'b1);
    chk("pp_gnt1", 32'(m_gnt), 32'h2);
    chk("pp_rv3", 32'(m_rvalid), 32'h8);
    chk("pp_outst_before", 32'(outstanding), 32'h1);
    tick();
    drive(4'b0000, 1'b0, 1'b1);
    chk("pp_outst_after", 32'(outstanding), 32'h1);
    chk("pp_rv1", 32'(m_rvalid), 32'h2);
    tick();

    // Orphan response with nothing in flight
    drive(4'b0000, 1'b0, 1'b1);
    chk("orph_rv", 32'(m_rvalid), 32'h0);
    chk("orph_outst", 32'(outstanding), 32'h0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    chk("orph_set", 32'(orphan), 32'h1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    chk("orph_sticky", 32'(orphan), 32'h1);
    chk("orph_no_underflow", 32'(outstanding), 32'h0);
    tick();

    // Two transactions in flight, then an asynchronous reset in mid-cycle
    drive(4'b0001, 1'b1, 1'b0);
    tick();
    drive(4'b0001, 1'b1, 1'b0);
    tick();
    drive(4'b0001, 1'b1, 1'b0);
    chk("pre_rst_outst", 32'(outstanding), 32'h2);
    rst = 1'b1;
    #1;
    chk("arst_outst", 32'(outstanding), 32'h0);
    chk("arst_orphan", 32'(orphan), 32'h0);
    chk("arst_sreq", 32'(s_req), 32'h0);
    chk("arst_gnt", 32'(m_gnt), 32'h0);
    chk("arst_addr", s_addr, addr_of(0));
    tick();
    rst = 1'b0;
    drive(4'hF, 1'b1, 1'b0);
    chk("post_rst_gnt", 32'(m_gnt), 32'h1);
    tick();
    drive(4'h0, 1'b0, 1'b1);
    chk("post_rst_rv", 32'(m_rvalid), 32'h1);
    tick();

`ifdef OBI_ARB_FIXED_PRIO_EN
    // Fixed priority: master 0 always beats master 3
    for (int k = 0; k < 3; k++) begin
      drive(4'b1001, 1'b1, k != 0);
      chk($sformatf("fp_gnt%0d", k), 32'(m_gnt), 32'h1);
      tick();
    end
    drive(4'b1000, 1'b1, 1'b1);
    chk("fp_gnt_m3", 32'(m_gnt), 32'h8);
    tick();
    drive(4'b0000, 1'b0, 1'b1);
    chk("fp_rv_m3", 32'(m_rvalid), 32'h8);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
